seq_pattern_detector: RTL

//   Parametrised serial bit-pattern detector; generalises the fixed 4-bit Mealy sequence detectors.

---
 rtl/seq_pattern_detector.sv | 108 ++++++++++
 1 files changed

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//   Serial bit-pattern detector with a parametrised pattern. It accepts one bit
//   per din_valid cycle and flags (Mealy, same cycle) when the last PAT_W
//   accepted bits equal the pattern, with the MSB received first. Overlapping
//   or non-overlapping detection is selected at run time. A saturating counter
//   tracks the number of matches since reset or clear.
//
//   Optional feature macro: SEQ_PATTERN_DETECTOR_PAT_LOAD_EN
//     When defined, adds pat_wr/pat_wdata so the pattern can be reloaded at
//     run time. The pattern register resets to PATTERN. A load flushes the
//     history like clear does, but leaves match_cnt unchanged.
//     When undefined, the pattern is the PATTERN constant.
module seq_pattern_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             overlap,
  input  logic             clear,
`ifdef SEQ_PATTERN_DETECTOR_PAT_LOAD_EN
  input  logic             pat_wr,
  input  logic [PAT_W-1:0] pat_wdata,
`endif
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W) + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist;      // last PAT_W-1 accepted bits, newest in LSB
  logic [FILL_W-1:0] fill;      // accepted bits that may take part in a match
  logic [FILL_W-1:0] fill_nxt;
  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  pattern;
  logic              load;      // pattern reload this cycle (flushes history)

`ifdef SEQ_PATTERN_DETECTOR_PAT_LOAD_EN
  logic [PAT_W-1:0] pat_reg;

  // Run-time pattern register; it comes out of reset holding PATTERN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_reg <= PATTERN;
    end else if (pat_wr) begin
      pat_reg <= pat_wdata;
    end
  end

  assign pattern = pat_reg;
  assign load    = pat_wr;
`else
  assign pattern = PATTERN;
  assign load    = 1'b0;
`endif

  assign window = {hist, din};

  // The reset term keeps match low while reset is asserted. The clear and
  // load terms make both of them win over a match in the same cycle.
  assign match = reset & din_valid & ~clear & ~load
               & (fill == FILL_FULL) & (window == pattern);

  // Fill update for an accepted bit. After a match, overlap mode keeps the
  // suffix usable. Non-overlap mode requires PAT_W fresh bits.
  always_comb begin
    // NOTE: assign the default first so that every path drives fill_nxt and no latch is inferred.
    fill_nxt = fill;
    if (match) begin
      fill_nxt = overlap ? FILL_FULL : '0;
    end else if (fill != FILL_FULL) begin
      fill_nxt = fill + 1'b1;
    end
  end

  // History, fill, delayed match flag and saturating match counter.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      match_cnt <= '0;
    end else begin
      match_q <= match;

      if (clear || load) begin
        hist <= '0;
        fill <= '0;
      end else if (din_valid) begin
        hist <= window[PAT_W-2:0];
        fill <= fill_nxt;
      end

      if (clear) begin
        match_cnt <= '0;
      end else if (match && !(&match_cnt)) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule
